// File: rtl/upscaler_pkg.sv
// rtl/upscaler_pkg.sv - shared widths, frame defaults and emitter state encoding
package upscaler_pkg;
  localparam int PIX_W      = 24;
  localparam int DEF_IMG_W  = 384;
  localparam int DEF_IMG_H  = 216;
  localparam int DEF_REPEAT = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } emit_state_e;

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead single-clock FIFO, drops writes while full
module sync_fifo
  import upscaler_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/upscale_feeder.sv
// rtl/upscale_feeder.sv - buffers source pixels and holds each one for REPEAT
// cycles toward the upscaler, tracking frame position and stream errors
module upscale_feeder
  import upscaler_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int REPEAT     = DEF_REPEAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic             s_ready,
  input  logic             err_clr,
  output logic [PIX_W-1:0] pixel_out,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic [15:0]      frame_cnt,
  output logic             underrun_err,
  output logic             sof_err
);
  localparam int PH_W = cnt_w(REPEAT);
  localparam int CW   = cnt_w(IMG_W);
  localparam int RW   = cnt_w(IMG_H);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(REPEAT - 1);
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);

  logic             fifo_full, fifo_empty, pop;
  logic [PIX_W:0]   fifo_rd;

  emit_state_e      state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CW-1:0]    col_q, col_d, adv_col;
  logic [RW-1:0]    row_q, row_d, adv_row;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [15:0]      frame_q, frame_d;
  logic             und_q, und_d, sof_err_q, sof_err_d;
  logic             last_ph, load, set_und, set_sof;

  // Ready depends only on FIFO occupancy, forced low while held in reset.
  assign s_ready = rst_n && !fifo_full;

  sync_fifo #(
    .WIDTH(PIX_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (s_valid),
    .wr_data_i({s_sof, s_pixel}),
    .rd_en_i  (pop),
    .rd_data_o(fifo_rd),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    pixel_d = pixel_q;
    pop     = 1'b0;
    set_und = 1'b0;
    set_sof = 1'b0;

    last_ph = (state_q == ST_EMIT) && (phase_q == PH_LAST);
    load    = !fifo_empty && ((state_q == ST_IDLE) || last_ph);

    if (col_q == COL_LAST) begin
      adv_col = '0;
      adv_row = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end else begin
      adv_col = col_q + CW'(1);
      adv_row = row_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (last_ph) begin
          col_d = adv_col;
          row_d = adv_row;
          if (!load) begin
            state_d = ST_IDLE;
            set_und = (adv_col != '0);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      phase_d = '0;
      pixel_d = fifo_rd[PIX_W-1:0];
      // A tagged start-of-frame pixel always lands at (0,0).
      if (fifo_rd[PIX_W] && ((col_d != '0) || (row_d != '0))) begin
        col_d   = '0;
        row_d   = '0;
        set_sof = 1'b1;
      end
    end

    valid_d   = (state_d == ST_EMIT);
    sof_d     = valid_d && (phase_d == '0) && (col_d == '0) && (row_d == '0);
    eol_d     = valid_d && (phase_d == PH_LAST) && (col_d == COL_LAST);
    eof_d     = eol_d && (row_d == ROW_LAST);
    frame_d   = frame_q + 16'(eof_d);
    und_d     = set_und ? 1'b1 : (err_clr ? 1'b0 : und_q);
    sof_err_d = set_sof ? 1'b1 : (err_clr ? 1'b0 : sof_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pixel_q   <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      frame_q   <= '0;
      und_q     <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pixel_q   <= pixel_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      frame_q   <= frame_d;
      und_q     <= und_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign pixel_out    = pixel_q;
  assign out_valid    = valid_q;
  assign out_sof      = sof_q;
  assign out_eol      = eol_q;
  assign out_eof      = eof_q;
  assign frame_cnt    = frame_q;
  assign underrun_err = und_q;
  assign sof_err      = sof_err_q;
endmodule

// File: tb/tb_upscale_feeder.sv
// tb/tb_upscale_feeder.sv - directed checks of upscale_feeder on a reduced 8x3 frame
module tb_upscale_feeder;
  localparam int W = 8;
  localparam int H = 3;
  localparam int R = 3;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] s_pixel = '0;
  logic        s_valid = 1'b0, s_sof = 1'b0, err_clr = 1'b0;
  logic        s_ready;
  logic [23:0] pixel_out;
  logic        out_valid, out_sof, out_eol, out_eof;
  logic [15:0] frame_cnt;
  logic        underrun_err, sof_err;

  upscale_feeder #(.IMG_W(W), .IMG_H(H), .REPEAT(R), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .s_pixel(s_pixel), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .err_clr(err_clr), .pixel_out(pixel_out), .out_valid(out_valid),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .frame_cnt(frame_cnt),
    .underrun_err(underrun_err), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int vcnt = 0, sofc = 0, eolc = 0, eofc = 0, first_c = 0, last_c = 0, seq_bad = 0;
  logic mon_clr = 1'b0;
  int rdy_hist [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Emitted stream: source pixel k carries value k, so the n-th valid cycle must show n/R.
  always @(negedge clk) begin
    if (mon_clr) begin
      vcnt = 0; sofc = 0; eolc = 0; eofc = 0; first_c = 0; last_c = 0; seq_bad = 0;
    end else if (out_valid) begin
      if (vcnt == 0) first_c = cyc;
      last_c = cyc;
      if (pixel_out !== 24'(vcnt / R)) seq_bad++;
      sofc += int'(out_sof);
      eolc += int'(out_eol);
      eofc += int'(out_eof);
      vcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    s_valid = 1'b0; s_sof = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic clr_mon;
    mon_clr = 1'b1;
    tick;
    mon_clr = 1'b0;
  endtask

  task automatic send(input int n, input int sof_a, input int sof_b);
    int   idx = 0;
    int   guard = 0;
    logic acc;
    while (idx < n && guard < 2000) begin
      s_valid = 1'b1;
      s_pixel = 24'(idx);
      s_sof   = (idx == sof_a) || (idx == sof_b);
      if (guard < 16) rdy_hist[guard] = int'(s_ready);
      acc = s_ready;
      tick;
      if (acc) idx++;
      guard++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    chk("send_done", idx, n);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 60 && out_valid; i++) tick;
    chk("idle_reached", out_valid, 1'b0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pixel", pixel_out, 24'h0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    chk("rst_flags", {underrun_err, sof_err, out_sof, out_eol, out_eof}, 5'b0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_ready", s_ready, 1'b1);

    // single pixel at idle
    s_valid = 1'b1; s_pixel = 24'h112233; s_sof = 1'b1;
    tick;
    s_valid = 1'b0; s_sof = 1'b0;
    chk("single_t0_valid", out_valid, 1'b0);
    tick;
    chk("single_p0", {out_valid, out_sof, pixel_out}, {2'b11, 24'h112233});
    tick;
    chk("single_p1", {out_valid, out_sof, pixel_out}, {2'b10, 24'h112233});
    tick;
    chk("single_p2", {out_valid, out_sof, pixel_out}, {2'b10, 24'h112233});
    tick;
    chk("single_end_valid", out_valid, 1'b0);
    chk("single_underrun", underrun_err, 1'b1);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("single_err_clr", underrun_err, 1'b0);

    // one whole frame, continuous source
    do_reset;
    clr_mon;
    send(W * H, 0, -1);
    wait_idle;
    chk("frame_vcnt", vcnt, W * H * R);
    chk("frame_span", last_c - first_c + 1, W * H * R);
    chk("frame_seq", seq_bad, 0);
    chk("frame_sof", sofc, 1);
    chk("frame_eol", eolc, H);
    chk("frame_eof", eofc, 1);
    chk("frame_cnt", frame_cnt, 16'd1);
    chk("frame_underrun", underrun_err, 1'b0);

    // reset during phase 1 with three pixels queued
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_pixel = 24'(k + 'h100); s_sof = 1'b0;
      tick;
    end
    s_valid = 1'b0;
    tick;
    chk("mid_pre_rst", {out_valid, pixel_out}, {1'b1, 24'h000101});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {out_valid, out_sof, out_eol, out_eof, s_ready}, 5'b0);
    chk("mid_rst_pixel", pixel_out, 24'h0);
    chk("mid_rst_frame", frame_cnt, 16'h0);
    tick;
    rst_n = 1'b1;
    tick;
    s_valid = 1'b1; s_pixel = 24'hABCDEF; s_sof = 1'b1;
    tick;
    s_valid = 1'b0; s_sof = 1'b0;
    tick;
    chk("mid_new_pixel", {out_valid, out_sof, pixel_out}, {2'b11, 24'hABCDEF});
    tick; tick; tick;
    chk("mid_no_leftover", out_valid, 1'b0);
    chk("mid_frame_cnt", frame_cnt, 16'h0);

    // backpressure: fill to four entries while emitter busy
    do_reset;
    clr_mon;
    send(W, 0, -1);
    chk("bp_rdy5", rdy_hist[5], 1);
    chk("bp_rdy6_full", rdy_hist[6], 0);
    chk("bp_rdy7_full", rdy_hist[7], 0);
    chk("bp_rdy8_pop", rdy_hist[8], 1);
    chk("bp_rdy9_full", rdy_hist[9], 0);
    wait_idle;
    chk("bp_vcnt", vcnt, W * R);
    chk("bp_seq", seq_bad, 0);
    chk("bp_eol", eolc, 1);

    // gap inside a line, then set-over-clear
    clr_mon;
    send(3, -1, -1);
    wait_idle;
    repeat (10) tick;
    chk("gap_underrun", underrun_err, 1'b1);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("gap_clr", underrun_err, 1'b0);
    err_clr = 1'b1;
    s_valid = 1'b1; s_pixel = 24'h55; s_sof = 1'b0;
    tick;
    s_valid = 1'b0;
    tick; tick; tick;
    chk("swc_before", {out_valid, underrun_err}, 2'b10);
    tick;
    chk("swc_set_wins", {out_valid, underrun_err}, 2'b01);
    err_clr = 1'b0;
    tick;
    chk("swc_sticky", underrun_err, 1'b1);

    // s_sof on column 5 row 2
    do_reset;
    clr_mon;
    send(2 * W + 5 + 1 + 7, 0, 2 * W + 5);
    wait_idle;
    chk("sof_err", sof_err, 1'b1);
    chk("sof_count", sofc, 2);
    chk("sof_eol", eolc, 3);
    chk("sof_eof", eofc, 0);
    chk("sof_frame_cnt", frame_cnt, 16'h0);
    chk("sof_seq", seq_bad, 0);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("sof_err_clr", sof_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
